cla_wide_add_seq: RTL and testbench

Multi-cycle wide adder/subtractor that sits directly around the 16-bit carry lookahead adder. It accepts a WIDTH-bit operand pair over a valid/ready handshake and feeds the CLA one NBIT-bit chunk per cycle, LSB chunk first, with a registered carry chained between chunks. It collects the chunk results into a WIDTH-bit sum and presents that sum downstream over a second valid/ready handshake.

---
 rtl/cla_pkg.sv | 17 +
 rtl/cla_wide_add_seq_cla.sv | 47 ++++
 rtl/cla_wide_add_seq.sv | 122 ++++++++++++
 tb/tb_cla_wide_add_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared state type and sizing defaults for the chunked wide CLA adder.
package cla_pkg;

   localparam int CLA_NBIT       = 16;
   localparam int CLA_NBITTOCELL = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } cla_seq_state_t;

   function automatic int num_chunks(input int width, input int nbit);
      return width / nbit;
   endfunction

endpackage

// File: rtl/cla_wide_add_seq_cla.sv
// NBIT-wide carry lookahead adder: full lookahead inside each NBITTOCELL
// cell, carries chained cell to cell.
module NBitCarryLookaheadAdder #(
   parameter int NBIT       = 16,
   parameter int NBITTOCELL = 4
) (
   input  logic [NBIT-1:0] a,
   input  logic [NBIT-1:0] b,
   input  logic            cin,
   output logic [NBIT-1:0] s,
   output logic            cout
);

   localparam int NCELL = NBIT / NBITTOCELL;

   logic [NBIT-1:0] g;
   logic [NBIT-1:0] p;
   logic [NBIT:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   always_comb begin
      logic x;
      logic pp;
      x    = 1'b0;
      pp   = 1'b0;
      c    = '0;
      c[0] = cin;
      for (int j = 0; j < NCELL; j++) begin
         for (int i = 0; i < NBITTOCELL; i++) begin
            // Expand carry i of this cell from the cell carry-in.
            x  = g[j*NBITTOCELL+i];
            pp = p[j*NBITTOCELL+i];
            for (int m = i - 1; m >= 0; m--) begin
               x  = x | (pp & g[j*NBITTOCELL+m]);
               pp = pp & p[j*NBITTOCELL+m];
            end
            c[j*NBITTOCELL+i+1] = x | (pp & c[j*NBITTOCELL]);
         end
      end
   end

   assign s    = p ^ c[NBIT-1:0];
   assign cout = c[NBIT];

endmodule

// File: rtl/cla_wide_add_seq.sv
// Multi-cycle WIDTH-bit add/sub feeding one shared CLA a chunk per cycle.
// Define CLA_SEQ_OVF_EN to compute and register signed overflow.
module cla_wide_add_seq
   import cla_pkg::*;
#(
   parameter int WIDTH      = 64,
   parameter int NBIT       = CLA_NBIT,
   parameter int NBITTOCELL = CLA_NBITTOCELL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NCHUNK = num_chunks(WIDTH, NBIT);
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

   if (WIDTH % NBIT != 0) begin : g_bad_width
      $error("cla_wide_add_seq: WIDTH must be a multiple of NBIT");
   end
   if (NBIT % NBITTOCELL != 0) begin : g_bad_cell
      $error("cla_wide_add_seq: NBIT must be a multiple of NBITTOCELL");
   end

   cla_seq_state_t   state_q;
   logic [KW-1:0]    k_q;
   logic [KW-1:0]    k_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             cout_q;
   logic [NBIT-1:0]  ca;
   logic [NBIT-1:0]  cb;
   logic [NBIT-1:0]  cs;
   logic             cc;

   assign k_d = k_q + 1'b1;
   assign ca  = a_q[NBIT*int'(k_q) +: NBIT];
   assign cb  = b_q[NBIT*int'(k_q) +: NBIT];

   NBitCarryLookaheadAdder #(
      .NBIT       (NBIT),
      .NBITTOCELL (NBITTOCELL)
   ) u_cla (
      .a    (ca),
      .b    (cb),
      .cin  (carry_q),
      .s    (cs),
      .cout (cc)
   );

`ifdef CLA_SEQ_OVF_EN
   logic ovf_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= op_sub ? ~b : b;
                  carry_q <= op_sub ? ~cin : cin;
                  k_q     <= '0;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               sum_q[NBIT*int'(k_q) +: NBIT] <= cs;
               carry_q <= cc;
               k_q     <= k_d;
               if (k_q == KLAST) begin
                  cout_q  <= cc;
`ifdef CLA_SEQ_OVF_EN
                  // Carry into the MSB recovered from the MSB sum bit.
                  ovf_q   <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ cs[NBIT-1] ^ cc;
`endif
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
`ifdef CLA_SEQ_OVF_EN
   assign ovf       = ovf_q;
`else
   assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Directed bench for cla_wide_add_seq with an arithmetic reference model
// compared every cycle, plus literal expectations on key vectors.
module tb_cla_wide_add_seq;

   localparam int NCHUNK = 4;
`ifdef CLA_SEQ_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic        cin = 1'b0;
   logic        op_sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] sum;
   logic        cout;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   cla_wide_add_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   // Reference model: transaction-level, timing from accept edge count.
   int          cyc = 0;
   int          done_cyc = 0;
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   logic [63:0] e_sum = '0;
   logic        e_cout = 1'b0;
   logic        e_ovf = 1'b0;
   int          acc_q[$];

   always @(posedge clk or posedge rst) begin
      logic [65:0] sx;
      logic [65:0] ux;
      if (rst) begin
         m_busy = 1'b0;
         m_done = 1'b0;
      end else begin
         cyc++;
         if (in_valid && in_ready) acc_q.push_back(cyc);
         if (m_done) begin
            if (out_ready) m_done = 1'b0;
         end else if (m_busy) begin
            if (cyc == done_cyc) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end else if (in_valid) begin
            sx = op_sub ? {{2{a[63]}}, a} - {{2{b[63]}}, b} - 66'(cin)
                        : {{2{a[63]}}, a} + {{2{b[63]}}, b} + 66'(cin);
            ux = op_sub ? {2'b00, a} - {2'b00, b} - 66'(cin)
                        : {2'b00, a} + {2'b00, b} + 66'(cin);
            e_sum    = sx[63:0];
            e_cout   = op_sub ? ~ux[65] : ux[64];
            e_ovf    = OVF_EN && !(sx[65:63] == 3'b000 || sx[65:63] == 3'b111);
            m_busy   = 1'b1;
            done_cyc = cyc + NCHUNK;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", 64'(in_ready), 64'(!m_busy && !m_done));
         chk("out_valid", 64'(out_valid), 64'(m_done));
         if (m_done) begin
            chk("m_sum", sum, e_sum);
            chk("m_cout", 64'(cout), 64'(e_cout));
            chk("m_ovf", 64'(ovf), 64'(e_ovf));
         end
      end
   end

   task automatic run_op(input string nm, input logic [63:0] av,
                         input logic [63:0] bv, input logic cv,
                         input logic sv, input logic ordy,
                         input logic [63:0] es, input logic ec,
                         input logic eo);
      int n;
      @(posedge clk); #1;
      a = av; b = bv; cin = cv; op_sub = sv;
      out_ready = ordy;
      in_valid  = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_lat"}, 64'(n), 64'(NCHUNK));
      chk({nm, "_sum"}, sum, es);
      chk({nm, "_cout"}, 64'(cout), 64'(ec));
      chk({nm, "_ovf"}, 64'(ovf), 64'(eo));
   endtask

   initial begin
      int n;
      int n0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #2;
      chk("rst_sum", sum, 64'h0);
      chk("rst_cout", 64'(cout), 64'h0);
      chk("rst_ovf", 64'(ovf), 64'h0);
      chk("rst_ovalid", 64'(out_valid), 64'h0);
      chk("rst_iready", 64'(in_ready), 64'h1);

      run_op("carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1,
             64'h0, 1'b1, 1'b0);
      run_op("sub0", 64'd5, 64'd7, 1'b0, 1'b1, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      run_op("sub1", 64'd5, 64'd7, 1'b1, 1'b1, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
      run_op("subpos", 64'd9, 64'd4, 1'b0, 1'b1, 1'b1,
             64'd5, 1'b1, 1'b0);
      run_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1,
             64'h8000_0000_0000_0000, 1'b0, OVF_EN);
      run_op("chunkc", 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_FFFF,
             1'b1, 1'b0, 1'b1, 64'h0000_0001_0000_FFFF, 1'b0, 1'b0);

      // Backpressure: hold result while new operands are offered.
      run_op("bp", 64'd3, 64'd4, 1'b0, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0);
      a = 64'd100; b = 64'd200; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("bp_sum", sum, 64'd7);
         chk("bp_cout", 64'(cout), 64'h0);
         chk("bp_ovf", 64'(ovf), 64'h0);
         chk("bp_iready", 64'(in_ready), 64'h0);
         chk("bp_ovalid", 64'(out_valid), 64'h1);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_done_ovalid", 64'(out_valid), 64'h0);
      chk("bp_done_iready", 64'(in_ready), 64'h1);

      // Reset in the middle of a run.
      a = 64'h1111_1111_1111_1111; b = 64'h2222_2222_2222_2222;
      cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      chk("mid_rst_sum", sum, 64'h0);
      chk("mid_rst_ovalid", 64'(out_valid), 64'h0);
      chk("mid_rst_cout", 64'(cout), 64'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("mid_rst_iready", 64'(in_ready), 64'h1);
      run_op("after_rst", 64'd1, 64'd2, 1'b0, 1'b0, 1'b1, 64'd3, 1'b0, 1'b0);

      // Back-to-back ops with both handshakes held open.
      @(posedge clk); #1;
      n0 = acc_q.size();
      a = 64'd10; b = 64'd20; cin = 1'b0; op_sub = 1'b0;
      out_ready = 1'b1; in_valid = 1'b1;
      n = 0;
      while (acc_q.size() < n0 + 1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      a = 64'd100; b = 64'd1; op_sub = 1'b1;
      while (acc_q.size() < n0 + 2 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      if (acc_q.size() >= n0 + 2)
         chk("b2b_space", 64'(acc_q[n0+1] - acc_q[n0]), 64'd6);
      else
         chk("b2b_accepts", 64'(acc_q.size() - n0), 64'd2);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b2b_sum2", sum, 64'd99);
      chk("b2b_cout2", 64'(cout), 64'h1);
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule
